// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO controllers: pointer code
// conversions and the default geometry used by both clock domains.
package fifo_pkg;

  localparam int DEFAULT_AW          = 3;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Callers zero-extend narrower pointers and cast the result back down.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_ff_n.sv
// Multi-flop synchronizer for bringing a Gray-coded bus into the local clock
// domain; stages are plain flops with nothing in between.
module sync_ff_n #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: write pointers, RAM write
// port control, full/almost_full, occupancy level and sticky overflow.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int AW           = DEFAULT_AW,
  parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
  parameter int AFULL_THRESH = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          ovf_clr,
  input  logic [AW:0]   g_rdpt_async,
  output logic [AW:0]   b_wrpt,
  output logic [AW:0]   g_wrpt,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wr_level,
  output logic          overflow
);

  localparam int PW = AW + 1;

  logic [PW-1:0] rq;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] next_b;
  logic [PW-1:0] next_g;
  logic [PW-1:0] next_level;
  logic [PW-1:0] full_match;
  logic          accept;

  sync_ff_n #(
    .WIDTH (PW),
    .STAGES(SYNC_STAGES)
  ) u_rd_sync (
    .clk(clk),
    .rst(rst),
    .d  (g_rdpt_async),
    .q  (rq)
  );

  assign accept     = we & ~full;
  assign mem_we     = accept;
  assign mem_waddr  = b_wrpt[AW-1:0];
  assign rd_bin     = PW'(gray2bin(32'(rq)));
  assign next_b     = b_wrpt + PW'(accept);
  assign next_g     = PW'(bin2gray(32'(next_b)));
  assign next_level = next_b - rd_bin;

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that means the top two bits differ and the rest match.
  assign full_match = {~rq[AW:AW-1], rq[AW-2:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_wrpt      <= '0;
      g_wrpt      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      b_wrpt      <= next_b;
      g_wrpt      <= next_g;
      full        <= (next_g == full_match);
      almost_full <= (next_level >= PW'(AFULL_THRESH));
      wr_level    <= next_level;
      if (we && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with a reference model feeding a scoreboard
// of expected post-edge outputs.
module tb_fifo_wr_ctrl;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [AW:0]   g_rdpt_async = '0;
  logic [AW:0]   b_wrpt;
  logic [AW:0]   g_wrpt;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] level;
    logic       full;
    logic       afull;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_b, m_s1, m_s2;
  logic       m_full, m_ovf;

  fifo_wr_ctrl #(
    .AW          (AW),
    .SYNC_STAGES (2),
    .AFULL_THRESH(6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .ovf_clr     (ovf_clr),
    .g_rdpt_async(g_rdpt_async),
    .b_wrpt      (b_wrpt),
    .g_wrpt      (g_wrpt),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input logic [3:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [3:0] to_bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_b    = '0;
    m_s1   = '0;
    m_s2   = '0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge: drive at negedge, predict, then compare after the edge.
  task automatic apply_stimulus(input logic w, input logic clr, input logic [3:0] grd);
    exp_t       e;
    exp_t       got;
    logic       acc;
    logic [3:0] nb;
    logic [3:0] lvl;
    @(negedge clk);
    we           = w;
    ovf_clr      = clr;
    g_rdpt_async = grd;
    acc = w & ~m_full;
    #1;
    check_output("mem_we", 32'(mem_we), 32'(acc));
    check_output("mem_waddr", 32'(mem_waddr), 32'(m_b[2:0]));
    nb      = m_b + {3'b000, acc};
    lvl     = nb - to_bin(m_s2);
    e.b     = nb;
    e.g     = to_gray(nb);
    e.level = lvl;
    e.full  = (lvl == 4'd8);
    e.afull = (lvl >= 4'd6);
    e.ovf   = (w & m_full) | (m_ovf & ~clr);
    sb.push_back(e);
    m_b    = nb;
    m_full = e.full;
    m_ovf  = e.ovf;
    m_s2   = m_s1;
    m_s1   = grd;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_output("b_wrpt", 32'(b_wrpt), 32'(got.b));
    check_output("g_wrpt", 32'(g_wrpt), 32'(got.g));
    check_output("wr_level", 32'(wr_level), 32'(got.level));
    check_output("full", 32'(full), 32'(got.full));
    check_output("almost_full", 32'(almost_full), 32'(got.afull));
    check_output("overflow", 32'(overflow), 32'(got.ovf));
  endtask

  initial begin
    logic [3:0] prev_b;
    logic [3:0] prev_g;
    logic       saw_full;
    logic       saw_wrap;
    logic       seq_found;
    logic [2:0] addr_q[$];

    reset_model();
    rst = 1'b0;
    we  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_b_wrpt", 32'(b_wrpt), 0);
    check_output("rst_g_wrpt", 32'(g_wrpt), 0);
    check_output("rst_full", 32'(full), 0);
    check_output("rst_afull", 32'(almost_full), 0);
    check_output("rst_level", 32'(wr_level), 0);
    check_output("rst_overflow", 32'(overflow), 0);
    check_output("rst_mem_we", 32'(mem_we), 1);
    we  = 1'b0;
    rst = 1'b1;

    // Fill from empty with the read pointer parked at zero.
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b1, 1'b0, 4'b0000);
      if (i == 1) check_output("first_b_wrpt", 32'(b_wrpt), 1);
      if (i == 5) check_output("fill5_afull", 32'(almost_full), 0);
      if (i == 6) begin
        check_output("fill6_level", 32'(wr_level), 6);
        check_output("fill6_afull", 32'(almost_full), 1);
      end
    end
    check_output("fill8_b_wrpt", 32'(b_wrpt), 32'h8);
    check_output("fill8_g_wrpt", 32'(g_wrpt), 32'hC);
    check_output("fill8_full", 32'(full), 1);
    check_output("fill8_level", 32'(wr_level), 8);

    // Rejected writes while full, then clear and set-wins-over-clear.
    apply_stimulus(1'b1, 1'b0, 4'b0000);
    apply_stimulus(1'b1, 1'b0, 4'b0000);
    check_output("ovf_b_hold", 32'(b_wrpt), 8);
    check_output("ovf_set", 32'(overflow), 1);
    apply_stimulus(1'b0, 1'b1, 4'b0000);
    check_output("ovf_clr", 32'(overflow), 0);
    apply_stimulus(1'b1, 1'b1, 4'b0000);
    check_output("ovf_set_wins", 32'(overflow), 1);
    apply_stimulus(1'b0, 1'b1, 4'b0000);

    // Read pointer advances by one; visible only after the sync lag.
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    check_output("drain1_full", 32'(full), 1);
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    check_output("drain2_full", 32'(full), 1);
    apply_stimulus(1'b0, 1'b0, 4'b0001);
    check_output("drain3_full", 32'(full), 0);
    check_output("drain3_level", 32'(wr_level), 7);

    // Let the reader catch up to two behind before streaming through the wrap.
    repeat (3) apply_stimulus(1'b0, 1'b0, to_gray(m_b - 4'd2));
    saw_full = 1'b0;
    saw_wrap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      prev_b = b_wrpt;
      prev_g = g_wrpt;
      addr_q.push_back(mem_waddr);
      apply_stimulus(1'b1, 1'b0, to_gray(m_b - 4'd2));
      saw_full = saw_full | full;
      if (prev_b == 4'd15) begin
        saw_wrap = 1'b1;
        check_output("wrap_prev_g", 32'(prev_g), 32'h8);
        check_output("wrap_b_wrpt", 32'(b_wrpt), 0);
        check_output("wrap_g_wrpt", 32'(g_wrpt), 0);
      end
    end
    seq_found = 1'b0;
    for (int i = 0; i + 2 < addr_q.size(); i++) begin
      if (addr_q[i] == 3'd7 && addr_q[i+1] == 3'd0 && addr_q[i+2] == 3'd1) seq_found = 1'b1;
    end
    check_output("wrap_seen", 32'(saw_wrap), 1);
    check_output("wrap_never_full", 32'(saw_full), 0);
    check_output("wrap_addr_seq", 32'(seq_found), 1);

    // Keep streaming to b_wrpt=5, then pull reset between edges.
    repeat (9) apply_stimulus(1'b1, 1'b0, to_gray(m_b - 4'd2));
    check_output("pre_rst_b_wrpt", 32'(b_wrpt), 5);
    #1;
    rst = 1'b0;
    #1;
    check_output("midrst_b_wrpt", 32'(b_wrpt), 0);
    check_output("midrst_g_wrpt", 32'(g_wrpt), 0);
    check_output("midrst_level", 32'(wr_level), 0);
    check_output("midrst_full", 32'(full), 0);
    check_output("midrst_afull", 32'(almost_full), 0);
    check_output("midrst_overflow", 32'(overflow), 0);
    reset_model();
    we           = 1'b0;
    g_rdpt_async = 4'b0000;
    rst          = 1'b1;
    apply_stimulus(1'b0, 1'b0, 4'b0000);
    check_output("post_rst_level", 32'(wr_level), 0);
    apply_stimulus(1'b1, 1'b0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Parametrised write-side controller for the dual-clock FIFO. It is the next generation of the write-pointer block.
- Runs entirely in the write clock domain.
- Owns the SYNC_STAGES-deep synchronizer for the read Gray pointer.
- Generates binary and Gray write pointers, memory write enable and address, registered full and almost_full, an occupancy level, and a sticky overflow flag.
- Sits between the producer and the FIFO RAM write port; the read-side controller consumes g_wrpt.

Parameters:
AW, 3, address width; DEPTH = 2**AW; AW >= 2
SYNC_STAGES, 2, flops in read-pointer synchronizer; >= 2
AFULL_THRESH, 6, almost_full asserts when level >= this; range 1..DEPTH

Ports:
clk  input  1  write-domain clock
rst  input  1  asynchronous active-low reset
we  input  1  producer write request
ovf_clr  input  1  clears overflow sticky flag
g_rdpt_async  input  AW+1  read Gray pointer, read clock domain
b_wrpt  output  AW+1  binary write pointer, registered
g_wrpt  output  AW+1  Gray write pointer, registered, to read domain
mem_we  output  1  RAM write enable = we & ~full (combinational)
mem_waddr  output  AW  RAM address = b_wrpt[AW-1:0]
full  output  1  registered full flag
almost_full  output  1  registered, level >= AFULL_THRESH
wr_level  output  AW+1  registered occupancy as seen by write side, 0..DEPTH
overflow  output  1  sticky: write attempted while full

Behaviour:
- Reset (rst=0, asynchronous):
  - b_wrpt, g_wrpt, full, almost_full, wr_level, overflow = 0.
  - All synchronizer flops = 0.
  - mem_we follows we & ~full, so it equals we during reset.
- Synchronizer: rq = output of last of SYNC_STAGES flops clocked on clk from g_rdpt_async. No logic between stages.
- rd_bin = Gray-to-binary of rq (combinational XOR prefix from MSB).
- Pointer update:
  - next_b = b_wrpt + (we & ~full).
  - next_g = next_b ^ (next_b >> 1).
  - Both are registered every edge.
  - Modulo 2**(AW+1) wrap: all-ones goes to 0 with no special case.
- Full: registered from next_g == {~rq[AW:AW-1], rq[AW-2:0]}.
  - Full asserts on the same edge that accepts the DEPTH-th outstanding write.
  - Full deassertion is pessimistic: SYNC_STAGES+1 edges after the read pointer changes.
- Level: wr_level <= next_b - rd_bin (AW+1-bit subtraction, modulo). Never exceeds DEPTH in legal operation.
- almost_full <= (next_b - rd_bin) >= AFULL_THRESH, updated on the same edge as wr_level.
- Overflow:
  - Set on the edge where we & full.
  - Cleared on the edge where ovf_clr=1.
  - Set wins if both occur on the same edge.
  - A rejected write leaves the pointers unchanged.
- Write accepted while full register is 0 and we=1; there is no other handshake and no wait states.
- Simultaneous write and read advance: level is unchanged once the read pointer is synchronized, and transiently overstates occupancy by the sync lag (safe direction).
- Reset mid-operation: all state clears immediately. The read side must also be reset; a mismatched reset is not supported.

Decomposition:
- Shared package fifo_pkg: gray2bin and bin2gray functions, and the default AW/SYNC_STAGES constants reused by the read-side controller.
- Sub-module: sync_ff_n, a parametrised width/stage-count synchronizer, active-low async reset. The read-side controller reuses it.

Test Plan:
All scenarios use AW=3, SYNC_STAGES=2, AFULL_THRESH=6.
- Reset: hold rst=0 with we=1 and clocks toggling -> all outputs 0, mem_we=1; release rst -> first edge gives b_wrpt=1.
- Fill: g_rdpt_async=0, we=1 for 8 edges:
  - after edge 6: wr_level=6, almost_full=1;
  - after edge 8: b_wrpt=4'b1000, g_wrpt=4'b1100, full=1, wr_level=8.
- Overflow: while full, we=1 for 2 edges -> b_wrpt stays 8, mem_we=0, overflow=1. Then ovf_clr=1, we=0 -> overflow=0 next edge. Then ovf_clr=1 together with we=1 while full -> overflow=1.
- Drain visibility: from full, set g_rdpt_async=4'b0001 -> full=0 and wr_level=7 after the 3rd edge; not earlier.
- Wrap: g_rdpt_async tracks the write pointer at distance 2 while writing 20 times -> b_wrpt passes 15->0, g_wrpt 4'b1000->4'b0000; full never asserts; mem_waddr sequence 7,0,1.
- Async reset mid-burst: assert rst low between edges at b_wrpt=5 -> outputs clear before the next edge; overflow and synchronizer clear.
